run_controller: RTL and testbench

//  Host-driven run/step/breakpoint sequencer for the single-cycle 19-bit-instruction datapath.

---
 rtl/run_ctrl_pkg.sv | 29 ++
 rtl/brk_match.sv | 52 +++++
 rtl/run_controller.sv | 146 ++++++++++++++
 tb/tb_run_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/step/breakpoint sequencer and its breakpoint bank.
package run_ctrl_pkg;

  localparam int BRK_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STOP  = 2'd1,
    OP_STEP  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_HOST = 3'd1,
    CAUSE_BRK  = 3'd2,
    CAUSE_STEP = 3'd3,
    CAUSE_HALT = 3'd4
  } cause_t;

endpackage

// File: rtl/brk_match.sv
// PC breakpoint register bank with comparators; reports a hit and the lowest matching index.
module brk_match
  import run_ctrl_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int NUM_BRK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            brk_wr,
  input  logic [2:0]      brk_idx,
  input  logic [PC_W-1:0] brk_addr,
  input  logic            brk_en,
  input  logic [PC_W-1:0] pc,
  input  logic            skip,
  output logic            hit,
  output logic [2:0]      hit_idx
);

  localparam int NB = (NUM_BRK > BRK_MAX) ? BRK_MAX : NUM_BRK;

  logic [PC_W-1:0] addr_q [NB];
  logic [NB-1:0]   en_q;

  // Indices at or above NB never match the loop, so such writes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) addr_q[i] <= '0;
      en_q <= '0;
    end else if (brk_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (brk_idx == 3'(i)) begin
          addr_q[i] <= brk_addr;
          en_q[i]   <= brk_en;
        end
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (en_q[i] && (addr_q[i] == pc)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
    if (skip) hit = 1'b0;
  end

endmodule

// File: rtl/run_controller.sv
// Host-driven run/step/breakpoint sequencer: gates decoder side-effect strobes and
// drives the datapath halt so a frozen PC never repeats an instruction's effects.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int NUM_BRK = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] step_count,
  input  logic             brk_wr,
  input  logic [2:0]       brk_idx,
  input  logic [PC_W-1:0]  brk_addr,
  input  logic             brk_en,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_insn,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic             no_change_in,
  output logic             reg_write,
  output logic             mem_write,
  output logic             push,
  output logic             pop,
  output logic             no_change,
  output logic             halt,
  output logic             dp_rst_req,
  output logic [2:0]       state,
  output logic [2:0]       stop_cause,
  output logic [2:0]       brk_hit_idx,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q;
  cause_t           cause_q;
  logic [CNT_W-1:0] steps_left;
  logic             skip_bp;
  logic             bp_hit;
  logic [2:0]       bp_idx;
  logic             active;
  logic             exec_en;
  logic             accept;

  brk_match #(.PC_W(PC_W), .NUM_BRK(NUM_BRK)) u_brk (
    .clk      (clk),
    .rst      (rst),
    .brk_wr   (brk_wr),
    .brk_idx  (brk_idx),
    .brk_addr (brk_addr),
    .brk_en   (brk_en),
    .pc       (pc),
    .skip     (skip_bp),
    .hit      (bp_hit),
    .hit_idx  (bp_idx)
  );

  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign exec_en   = active && !halt_insn && !bp_hit;
  assign cmd_ready = (state_q != ST_STEP) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;

  // Strobe gating is combinational so a stop applies in the very cycle it is detected.
  assign reg_write  = reg_write_in & exec_en;
  assign mem_write  = mem_write_in & exec_en;
  assign push       = push_in & exec_en;
  assign pop        = pop_in & exec_en;
  assign no_change  = no_change_in | ~exec_en;
  assign halt       = ~exec_en;
  assign state      = state_q;
  assign stop_cause = cause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cause_q       <= CAUSE_NONE;
      brk_hit_idx   <= 3'd0;
      cycle_count   <= '0;
      retired_count <= '0;
      steps_left    <= '0;
      skip_bp       <= 1'b0;
      dp_rst_req    <= 1'b0;
    end else begin
      dp_rst_req <= 1'b0;
      if (active) cycle_count <= sat_inc(cycle_count);
      if (exec_en) begin
        retired_count <= sat_inc(retired_count);
        skip_bp       <= 1'b0;
      end
      unique case (state_q)
        ST_RUN, ST_STEP: begin
          if (halt_insn) begin
            state_q <= ST_DONE;
            cause_q <= CAUSE_HALT;
          end else if (bp_hit) begin
            state_q     <= ST_PAUSED;
            cause_q     <= CAUSE_BRK;
            brk_hit_idx <= bp_idx;
          end else if (accept && (cmd_op == OP_STOP)) begin
            state_q <= ST_PAUSED;
            cause_q <= CAUSE_HOST;
          end else if (state_q == ST_STEP) begin
            if (steps_left == CNT_W'(1)) begin
              state_q <= ST_PAUSED;
              cause_q <= CAUSE_STEP;
            end else begin
              steps_left <= steps_left - CNT_W'(1);
            end
          end
        end
        ST_IDLE, ST_PAUSED: begin
          if (accept && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
            // Resuming from a breakpoint must let the breakpointed instruction execute once.
            skip_bp <= (state_q == ST_PAUSED) && (cause_q == CAUSE_BRK);
            if (cmd_op == OP_RUN) begin
              state_q <= ST_RUN;
            end else begin
              state_q    <= ST_STEP;
              steps_left <= (step_count == '0) ? CNT_W'(1) : step_count;
            end
          end
        end
        default: ;
      endcase
      if (accept && (cmd_op == OP_CLEAR)) begin
        state_q       <= ST_IDLE;
        cause_q       <= CAUSE_NONE;
        cycle_count   <= '0;
        retired_count <= '0;
        skip_bp       <= 1'b0;
        dp_rst_req    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a PC that advances whenever halt is low, with a scoreboard of expected retiring PCs.
module tb_run_controller;
  import run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] step_count;
  logic        brk_wr;
  logic [2:0]  brk_idx;
  logic [11:0] brk_addr;
  logic        brk_en;
  logic [11:0] pc;
  logic        halt_insn;
  logic        reg_write_in, mem_write_in, push_in, pop_in, no_change_in;
  logic        reg_write, mem_write, push, pop, no_change, halt, dp_rst_req;
  logic [2:0]  state, stop_cause, brk_hit_idx;
  logic [15:0] cycle_count, retired_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] sb [$];

  run_controller #(.PC_W(12), .NUM_BRK(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .step_count(step_count), .brk_wr(brk_wr), .brk_idx(brk_idx), .brk_addr(brk_addr),
    .brk_en(brk_en), .pc(pc), .halt_insn(halt_insn), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .push_in(push_in), .pop_in(pop_in),
    .no_change_in(no_change_in), .reg_write(reg_write), .mem_write(mem_write), .push(push),
    .pop(pop), .no_change(no_change), .halt(halt), .dp_rst_req(dp_rst_req), .state(state),
    .stop_cause(stop_cause), .brk_hit_idx(brk_hit_idx), .cycle_count(cycle_count),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the modelled datapath PC advances only when halt was low.
  task automatic tick();
    logic h;
    @(negedge clk);
    h = halt;
    @(posedge clk);
    #1;
    if (h === 1'b0) pc = pc + 12'd1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    step_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wr_brk(input logic [2:0] idx, input logic [11:0] a, input logic en);
    brk_wr = 1'b1; brk_idx = idx; brk_addr = a; brk_en = en;
    tick();
    brk_wr = 1'b0;
  endtask

  task automatic push_range(input logic [11:0] lo, input logic [11:0] hi);
    for (logic [12:0] a = {1'b0, lo}; a <= {1'b0, hi}; a++) sb.push_back(a[11:0]);
  endtask

  task automatic run_until(input logic [2:0] st, input int max_cyc, input string tag);
    int n = 0;
    while (state !== st && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(st));
  endtask

  // Retire monitor: every retiring cycle must match the next expected PC.
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_retire", 32'(pc), 32'hFFFF_FFFF);
      else chk("retire_pc", 32'(pc), 32'(sb.pop_front()));
      chk("strobes_on_retire", 32'({mem_write, push, pop, no_change}), 32'b1110);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_RUN; step_count = '0;
    brk_wr = 1'b0; brk_idx = '0; brk_addr = '0; brk_en = 1'b0; pc = '0;
    halt_insn = 1'b0; reg_write_in = 1'b1; mem_write_in = 1'b1; push_in = 1'b1;
    pop_in = 1'b1; no_change_in = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_halt", 32'(halt), 1);
    chk("rst_strobes", 32'({reg_write, mem_write, push, pop}), 0);
    chk("rst_no_change", 32'(no_change), 1);
    chk("rst_state", 32'(state), 0);
    chk("rst_cause", 32'(stop_cause), 0);
    chk("rst_counts", 32'({cycle_count, retired_count}), 0);
    chk("rst_dp_rst_req", 32'(dp_rst_req), 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("idle_halt", 32'(halt), 1);
    chk("idle_state", 32'(state), 0);
    chk("idle_strobes", 32'({reg_write, mem_write, push, pop}), 0);

    // STEP 3 from IDLE
    push_range(12'h000, 12'h002);
    issue(OP_STEP, 16'd3);
    for (int i = 0; i < 5; i++) tick();
    chk("step3_state", 32'(state), 32'(ST_PAUSED));
    chk("step3_cause", 32'(stop_cause), 32'(CAUSE_STEP));
    chk("step3_retired", 32'(retired_count), 3);
    chk("step3_cycles", 32'(cycle_count), 3);
    chk("step3_pc", 32'(pc), 32'h003);

    // Breakpoint at 0x010 on idx1; disabled idx0 and out-of-range idx5 must not stop
    wr_brk(3'd1, 12'h010, 1'b1);
    wr_brk(3'd0, 12'h00C, 1'b0);
    wr_brk(3'd5, 12'h008, 1'b1);
    push_range(12'h003, 12'h00F);
    issue(OP_RUN, 16'd0);
    run_until(3'(ST_PAUSED), 40, "brk_reach_pause");
    chk("brk_cause", 32'(stop_cause), 32'(CAUSE_BRK));
    chk("brk_idx", 32'(brk_hit_idx), 1);
    chk("brk_pc", 32'(pc), 32'h010);
    chk("brk_retired", 32'(retired_count), 16);

    // Resume past the breakpoint, then STOP with no hit: that cycle retires
    push_range(12'h010, 12'h013);
    issue(OP_RUN, 16'd0);
    tick(); tick(); tick();
    issue(OP_STOP, 16'd0);
    chk("stop_state", 32'(state), 32'(ST_PAUSED));
    chk("stop_cause", 32'(stop_cause), 32'(CAUSE_HOST));
    chk("stop_pc", 32'(pc), 32'h014);
    chk("stop_retired", 32'(retired_count), 20);

    // STOP in the same cycle as a hit on both entries: BRK wins, lowest index
    wr_brk(3'd0, 12'h016, 1'b1);
    wr_brk(3'd1, 12'h016, 1'b1);
    push_range(12'h014, 12'h015);
    issue(OP_RUN, 16'd0);
    tick(); tick();
    issue(OP_STOP, 16'd0);
    chk("stopbrk_state", 32'(state), 32'(ST_PAUSED));
    chk("stopbrk_cause", 32'(stop_cause), 32'(CAUSE_BRK));
    chk("stopbrk_idx", 32'(brk_hit_idx), 0);
    chk("stopbrk_pc", 32'(pc), 32'h016);
    chk("stopbrk_retired", 32'(retired_count), 22);
    chk("stopbrk_cycles", 32'(cycle_count), 24);

    // halt_insn in RUN
    wr_brk(3'd0, 12'h016, 1'b0);
    wr_brk(3'd1, 12'h016, 1'b0);
    push_range(12'h016, 12'h017);
    issue(OP_RUN, 16'd0);
    tick(); tick();
    halt_insn = 1'b1;
    #2;
    chk("halti_state_run", 32'(state), 32'(ST_RUN));
    chk("halti_mem_write", 32'(mem_write), 0);
    chk("halti_halt", 32'(halt), 1);
    tick();
    halt_insn = 1'b0;
    chk("done_state", 32'(state), 32'(ST_DONE));
    chk("done_cause", 32'(stop_cause), 32'(CAUSE_HALT));
    issue(OP_RUN, 16'd0);
    tick(); tick();
    chk("done_ignores_run", 32'(state), 32'(ST_DONE));
    chk("done_ready", 32'(cmd_ready), 1);
    issue(OP_CLEAR, 16'd0);
    chk("clear_pulse", 32'(dp_rst_req), 1);
    chk("clear_state", 32'(state), 0);
    chk("clear_cause", 32'(stop_cause), 0);
    chk("clear_counts", 32'({cycle_count, retired_count}), 0);
    tick();
    chk("clear_pulse_end", 32'(dp_rst_req), 0);

    // STEP with count 0 behaves as 1; non-STOP command blocked during STEP
    push_range(12'h018, 12'h018);
    issue(OP_STEP, 16'd0);
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    #2;
    chk("step_ready_blocked", 32'(cmd_ready), 0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("step0_state", 32'(state), 32'(ST_PAUSED));
    chk("step0_cause", 32'(stop_cause), 32'(CAUSE_STEP));
    chk("step0_retired", 32'(retired_count), 1);
    chk("paused_ready", 32'(cmd_ready), 1);

    // Asynchronous reset mid-run
    push_range(12'h019, 12'h01A);
    issue(OP_RUN, 16'd0);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_strobes", 32'({reg_write, mem_write, push, pop}), 0);
    chk("async_halt", 32'(halt), 1);
    chk("async_retired", 32'(retired_count), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("async_idle_after", 32'(state), 0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
